// File: rtl/nn_host_slave.sv
// nn_host_slave: host memory-mapped responder driving memory writes/reads, control/status registers and core start/done handshake
module nn_host_slave #(
  parameter int MM_DEPTH = 16,
  parameter int MM_WIDTH = 16,
  parameter int Q_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_enable,
  input  logic [MM_DEPTH-1:0] write_addr,
  input  logic [MM_WIDTH-1:0] write_data,
  input  logic                read_enable,
  input  logic [MM_DEPTH-1:0] read_addr,
  output logic [Q_DEPTH-1:0]  read_data,
  output logic                available,
  output logic                mem_we,
  output logic [MM_DEPTH-3:0] mem_waddr,
  output logic [MM_WIDTH-1:0] mem_wdata,
  output logic [MM_DEPTH-3:0] mem_raddr,
  input  logic [MM_WIDTH-1:0] mem_rdata,
  output logic                core_start,
  input  logic                core_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic run, wr_reg, rd_reg, wr_ctrl, start_req, start_ok, mem_wr, mem_ok;
  logic err, rd_pend, rd_is_reg;
  logic [15:0] cycles, reg_val, rd_val;
  assign run = state == RUN;
  assign wr_reg = write_addr[MM_DEPTH-1 -: 2] == 2'b11;
  assign rd_reg = read_addr[MM_DEPTH-1 -: 2] == 2'b11;
  assign wr_ctrl = write_enable && wr_reg && write_addr[1:0] == 2'd0;
  assign start_req = wr_ctrl && write_data[0];
  assign start_ok = start_req && !run;
  assign mem_wr = write_enable && !wr_reg;
  assign mem_ok = mem_wr && !run;
  assign mem_raddr = read_addr[MM_DEPTH-3:0];
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_comb
    state_nxt = start_ok ? RUN : (run && core_done) ? DONE : state;
  always_comb
    available = !run;
  always_comb
    reg_val = (read_addr[1:0] == 2'd1) ? {13'd0, err, run, !run} :
              (read_addr[1:0] == 2'd2) ? cycles : 16'd0;
  always_ff @(posedge clk)
    if (reset) begin
      core_start <= 1'b0;
      mem_we <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      err <= 1'b0;
      cycles <= 16'd0;
      rd_pend <= 1'b0;
      rd_is_reg <= 1'b0;
      rd_val <= 16'd0;
      read_data <= '0;
    end else begin
      core_start <= start_ok;
      mem_we <= mem_ok;
      if (mem_ok) begin
        mem_waddr <= write_addr[MM_DEPTH-3:0];
        mem_wdata <= write_data;
      end
      err <= (run && (start_req || mem_wr)) ? 1'b1 : (wr_ctrl && write_data[1]) ? 1'b0 : err;
      cycles <= start_ok ? 16'd0 : (run && cycles != 16'hFFFF) ? cycles + 16'd1 : cycles;
      rd_pend <= read_enable;
      if (read_enable) begin
        rd_is_reg <= rd_reg;
        rd_val <= reg_val;
      end
      if (rd_pend)
        read_data <= rd_is_reg ? Q_DEPTH'(rd_val) : Q_DEPTH'(mem_rdata);
    end
endmodule

// File: tb/tb_nn_host_slave.sv
// tb_nn_host_slave: directed and randomized checks of nn_host_slave against a behavioural model
module tb_nn_host_slave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic write_enable = 1'b0, read_enable = 1'b0, core_done = 1'b0;
  logic [15:0] write_addr = 16'd0, write_data = 16'd0, read_addr = 16'd0;
  logic [15:0] read_data, mem_wdata, mem_rdata;
  logic available, mem_we, core_start;
  logic [13:0] mem_waddr, mem_raddr;
  logic [15:0] mem [0:16383];
  logic [15:0] ref_mem [0:16383];
  bit m_busy, m_err;
  int m_cyc;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  nn_host_slave dut (
    .clk(clk),
    .reset(reset),
    .write_enable(write_enable),
    .write_addr(write_addr),
    .write_data(write_data),
    .read_enable(read_enable),
    .read_addr(read_addr),
    .read_data(read_data),
    .available(available),
    .mem_we(mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .core_start(core_start),
    .core_done(core_done)
  );
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    bit start, clr, memw;
    start = write_enable && write_addr[15:14] == 2'b11 && write_addr[1:0] == 2'b00 && write_data[0];
    clr = write_enable && write_addr[15:14] == 2'b11 && write_addr[1:0] == 2'b00 && write_data[1];
    memw = write_enable && write_addr[15:14] != 2'b11;
    if (reset) begin
      m_busy = 1'b0;
      m_err = 1'b0;
      m_cyc = 0;
    end else begin
      if (memw && !m_busy) ref_mem[write_addr[13:0]] = write_data;
      m_err = (m_busy && (start || memw)) ? 1'b1 : clr ? 1'b0 : m_err;
      if (m_busy) begin
        m_cyc = (m_cyc < 65535) ? m_cyc + 1 : 65535;
        m_busy = !core_done;
      end else if (start) begin
        m_busy = 1'b1;
        m_cyc = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] expect_read(input logic [15:0] a);
    if (a[15:14] != 2'b11) return ref_mem[a[13:0]];
    case (a[1:0])
      2'd1: return {13'd0, m_err, m_busy, !m_busy};
      2'd2: return 16'(m_cyc);
      default: return 16'd0;
    endcase
  endfunction
  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    bit exp_we;
    exp_we = a[15:14] != 2'b11 && !m_busy;
    write_enable = 1'b1;
    write_addr = a;
    write_data = d;
    tick();
    write_enable = 1'b0;
    chk("mem_we", mem_we, exp_we);
    if (exp_we) begin
      chk("mem_waddr", mem_waddr, a[13:0]);
      chk("mem_wdata", mem_wdata, d);
    end
    tick();
  endtask
  task automatic do_read(input logic [15:0] a, input string tag);
    logic [15:0] e;
    e = expect_read(a);
    read_enable = 1'b1;
    read_addr = a;
    tick();
    read_enable = 1'b0;
    tick();
    chk(tag, read_data, e);
  endtask
  task automatic run_core(input int n);
    write_enable = 1'b1;
    write_addr = 16'hC000;
    write_data = 16'h0001;
    tick();
    write_enable = 1'b0;
    chk("start_pulse", core_start, 1);
    chk("avail_run", available, 0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("start_low", core_start, 0);
      chk("avail_run", available, 0);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("avail_done", available, 1);
  endtask
  initial begin
    logic [15:0] addrs [8];
    logic [15:0] exp_b [5];
    logic [15:0] d, e;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_available", available, 1);
    chk("rst_read_data", read_data, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_core_start", core_start, 0);
    do_write(16'h0010, 16'h1234);
    do_read(16'h0010, "rd_0010");
    chk("rd_0010_const", read_data, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 16'($urandom_range(0, 16'hBFFF));
      do_write(addrs[i], 16'($urandom));
    end
    for (int i = 0; i < 8; i++) do_read(addrs[i], "rd_rand");
    do_write(16'h0020, 16'($urandom));
    for (int i = 0; i < 4; i++) do_write(16'(i), 16'($urandom));
    do_write(16'hC003, 16'hFFFF);
    chk("rsvd_no_start", available, 1);
    do_read(16'hC003, "rd_rsvd");
    run_core(20);
    do_read(16'hC002, "cycles_21");
    chk("cycles_21_const", read_data, 16'd21);
    run_core(int'($urandom_range(2, 30)));
    do_read(16'hC002, "cycles_rand");
    write_enable = 1'b1;
    write_addr = 16'hC000;
    write_data = 16'h0001;
    tick();
    chk("start_pulse2", core_start, 1);
    write_addr = 16'h0020;
    write_data = 16'($urandom);
    tick();
    chk("drop_mem_we", mem_we, 0);
    write_addr = 16'hC000;
    write_data = 16'h0001;
    tick();
    write_enable = 1'b0;
    chk("no_restart", core_start, 0);
    do_read(16'hC001, "status_busy_err");
    chk("status_6", read_data, 16'h0006);
    do_read(16'h0020, "rd_during_run");
    do_read(16'hC002, "cycles_live");
    do_write(16'hC000, 16'h0003);
    do_read(16'hC001, "status_clr_start");
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("avail_after_done", available, 1);
    do_read(16'hC001, "status_done_err");
    do_write(16'hC000, 16'h0002);
    do_read(16'hC001, "status_cleared");
    chk("status_1", read_data, 16'h0001);
    e = expect_read(16'hC001);
    write_enable = 1'b1;
    write_addr = 16'hC000;
    write_data = 16'h0001;
    read_enable = 1'b1;
    read_addr = 16'hC001;
    tick();
    write_enable = 1'b0;
    read_enable = 1'b0;
    chk("start_with_read", core_start, 1);
    tick();
    chk("status_pre_write", read_data, e);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    d = 16'($urandom);
    e = expect_read(16'h0003);
    write_enable = 1'b1;
    write_addr = 16'h0040;
    write_data = d;
    read_enable = 1'b1;
    read_addr = 16'h0003;
    tick();
    write_enable = 1'b0;
    read_enable = 1'b0;
    chk("wr_rd_we", mem_we, 1);
    chk("wr_rd_wdata", mem_wdata, d);
    tick();
    chk("wr_rd_rdata", read_data, e);
    do_read(16'h0040, "rd_0040");
    write_enable = 1'b1;
    write_addr = 16'hC000;
    write_data = 16'h0001;
    tick();
    write_enable = 1'b0;
    repeat (5) tick();
    chk("avail_mid_run", available, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("avail_reset", available, 1);
    chk("start_reset", core_start, 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("avail_stray_done", available, 1);
    do_read(16'hC002, "cycles_reset");
    do_read(16'hC001, "status_reset");
    for (int i = 0; i < 5; i++) exp_b[i] = expect_read((i < 4) ? 16'(i) : 16'hC001);
    for (int i = 0; i <= 5; i++) begin
      read_enable = i < 5;
      read_addr = (i < 4) ? 16'(i) : 16'hC001;
      tick();
      if (i > 0) chk("b2b", read_data, exp_b[i-1]);
    end
    read_enable = 1'b0;
    tick();
    chk("b2b_hold", read_data, exp_b[4]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
